// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a header byte (word count, 0 = full capacity) followed by a
// little-endian byte stream. It writes each assembled 32-bit word to
// sequential addresses starting at 0. The core stays held until the
// last word has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state;
  logic [1:0]            lane;
  logic [DATA_WIDTH-9:0] word_acc;   // lanes 0..2; lane 3 goes straight to wr_data
  logic [CNT_W-1:0]      target;     // programmed word count N
  logic [CNT_W-1:0]      count_inc;
  logic                  xfer;

  // Header decode: the low ADDR_WIDTH bits give N, where zero means full capacity.
  function automatic logic [CNT_W-1:0] decode_count(input logic [7:0] hdr);
    logic [ADDR_WIDTH-1:0] n;
    n = hdr[ADDR_WIDTH-1:0];
    if (n == '0) decode_count = CNT_W'(MAX_WORDS);
    else         decode_count = {1'b0, n};
  endfunction

  // Handshake and next word count, used by the state machine.
  always_comb begin
    xfer      = byte_valid && byte_ready;
    count_inc = word_count + CNT_W'(1);
  end

  // Loader state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      lane       <= 2'd0;
      word_acc   <= '0;
      target     <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_HEADER;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
            wr_addr    <= '0;
            word_count <= '0;
          end
        end

        S_HEADER: begin
          if (xfer) begin
            target <= decode_count(byte_in);
            lane   <= 2'd0;
            state  <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (xfer) begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_acc[7:0]   <= byte_in;
              2'd1: word_acc[15:8]  <= byte_in;
              2'd2: word_acc[23:16] <= byte_in;
              default: begin
                // Last lane: present the word and strobe the write next cycle.
                wr_data    <= {byte_in, word_acc};
                wr_en      <= 1'b1;
                byte_ready <= 1'b0;
                state      <= S_WRITE;
              end
            endcase
          end
        end

        S_WRITE: begin
          // The address wraps naturally after the last word of a full-size load.
          word_count <= count_inc;
          wr_addr    <= wr_addr + ADDR_WIDTH'(1);
          lane       <= 2'd0;
          if (count_inc == target) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state      <= S_COLLECT;
            byte_ready <= 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [6:0]  word_count;

  int n_tests = 0;
  int n_fail  = 0;
  int last_waits;

  logic [5:0]  obs_addr [$];
  logic [31:0] obs_data [$];
  logic [7:0]  stream2 [0:8];

  imem_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .MAX_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every write strobe; the loader must not offer ready while writing.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
      check("ready_low_in_write", byte_ready, 1'b0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits = 0;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) check("byte_ready_timeout", 0, 1);
    last_waits = waits;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    byte_valid = 1'b0;
    @(negedge clk);
    while (done !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic check_write(input string tag, input int idx, input logic [5:0] a, input logic [31:0] d);
    if (obs_addr.size() > idx) begin
      check({tag, "_addr"}, obs_addr[idx], a);
      check({tag, "_data"}, obs_data[idx], d);
    end else begin
      check({tag, "_missing"}, 0, 1);
    end
  endtask

  initial begin
    stream2 = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    // 1: reset held for two edges with start and valid asserted
    reset = 1'b0; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 6'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_word_count", word_count, 7'd0);
    check("rst_no_writes", obs_addr.size(), 0);
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_byte_ready", byte_ready, 1'b0);

    // 2: two words, back-to-back stream
    clear_obs();
    pulse_start();
    check("s2_busy_after_start", busy, 1'b1);
    check("s2_hold_after_start", cpu_hold, 1'b1);
    for (int k = 0; k < 9; k++) begin
      send_byte(stream2[k]);
      if (k == 5) check("s2_wait_over_write", last_waits, 1);
    end
    wait_done("s2_done_timeout");
    check("s2_nwrites", obs_addr.size(), 2);
    check_write("s2_w0", 0, 6'd0, 32'h0000_0013);
    check_write("s2_w1", 1, 6'd1, 32'h0010_0093);
    check("s2_cpu_hold", cpu_hold, 1'b0);
    check("s2_busy", busy, 1'b0);
    check("s2_word_count", word_count, 7'd2);
    check("s2_wr_addr", wr_addr, 6'd2);
    check("s2_byte_ready", byte_ready, 1'b0);

    // 3: same stream with gaps; the byte after a word is held across WRITE
    clear_obs();
    pulse_start();
    check("s3_done_cleared", done, 1'b0);
    check("s3_hold_reasserted", cpu_hold, 1'b1);
    check("s3_count_cleared", word_count, 7'd0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0 && k != 5) idle(1 + (k % 3));
      send_byte(stream2[k]);
      if (k == 5) check("s3_held_byte_wait", last_waits, 1);
    end
    wait_done("s3_done_timeout");
    check("s3_nwrites", obs_addr.size(), 2);
    check_write("s3_w0", 0, 6'd0, 32'h0000_0013);
    check_write("s3_w1", 1, 6'd1, 32'h0010_0093);
    check("s3_word_count", word_count, 7'd2);

    // 4: header 0 means 64 words; address wraps back to 0
    clear_obs();
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i));
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
    end
    wait_done("s4_done_timeout");
    check("s4_nwrites", obs_addr.size(), 64);
    for (int i = 0; i < 64; i++) check_write("s4_w", i, 6'(i), 32'(i));
    check("s4_word_count", word_count, 7'd64);
    check("s4_wr_addr_wrap", wr_addr, 6'd0);
    check("s4_cpu_hold", cpu_hold, 1'b0);

    // 5: reset in the middle of word 1 aborts the load
    clear_obs();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("s5_nwrites", obs_addr.size(), 1);
    check_write("s5_w0", 0, 6'd0, 32'h4433_2211);
    check("s5_busy", busy, 1'b0);
    check("s5_byte_ready", byte_ready, 1'b0);
    check("s5_cpu_hold", cpu_hold, 1'b1);
    check("s5_done", done, 1'b0);
    check("s5_word_count", word_count, 7'd0);
    check("s5_wr_addr", wr_addr, 6'd0);
    clear_obs();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done("s5_fresh_done_timeout");
    check("s5_fresh_nwrites", obs_addr.size(), 1);
    check_write("s5_fresh_w0", 0, 6'd0, 32'h0403_0201);

    // 6: start mid-load ignored, then restart from DONE
    clear_obs();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    byte_valid = 1'b0;
    pulse_start();
    send_byte(8'h11); send_byte(8'h21);
    byte_valid = 1'b0;
    pulse_start();
    send_byte(8'h31); send_byte(8'h41);
    send_byte(8'h12); send_byte(8'h22); send_byte(8'h32); send_byte(8'h42);
    wait_done("s6_done_timeout");
    check("s6_nwrites", obs_addr.size(), 3);
    check_write("s6_w0", 0, 6'd0, 32'h4030_2010);
    check_write("s6_w1", 1, 6'd1, 32'h4131_2111);
    check_write("s6_w2", 2, 6'd2, 32'h4232_2212);
    check("s6_word_count", word_count, 7'd3);
    clear_obs();
    pulse_start();
    check("s6_done_cleared", done, 1'b0);
    check("s6_hold_reasserted", cpu_hold, 1'b1);
    check("s6_addr_restart", wr_addr, 6'd0);
    send_byte(8'h01);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_done("s6_reload_done_timeout");
    check("s6_reload_nwrites", obs_addr.size(), 1);
    check_write("s6_reload_w0", 0, 6'd0, 32'hDEAD_BEEF);
    check("s6_reload_word_count", word_count, 7'd1);
    check("s6_reload_cpu_hold", cpu_hold, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
